// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants and the int-to-float stage payload
package fpu_pkg;

  localparam int INT_W    = 32;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int SIG_W    = 24;
  localparam int EXP_BIAS = 127;

  // S2 -> S3 payload: normalized significand with hidden one at sig[SIG_W-1]
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             guard;
    logic             sticky;
    logic             zero;
  } stage_t;

endpackage

// File: rtl/itof_pipe_if.sv
// rtl/itof_pipe_if.sv - operand/result handshake bundle for itof_pipe
interface itof_pipe_if;
  import fpu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [INT_W-1:0] in_x;
  logic             out_valid;
  logic             out_ready;
  logic [INT_W-1:0] out_y;

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_y
  );

endinterface

// File: rtl/lzc32.sv
// rtl/lzc32.sv - combinational 32-bit leading-zero counter, 32 for a zero input
module lzc32 (
  input  logic [31:0] i_x,
  output logic [5:0]  o_cnt
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    o_cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (i_x[i]) o_cnt = 6'(31 - i);
    end
  end

endmodule

// File: rtl/itof_pipe.sv
// rtl/itof_pipe.sv - 3-stage int32 to IEEE-754 single converter
// ITOF_RNE_EN defined: round to nearest even; undefined: truncate toward zero.
module itof_pipe
  import fpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  itof_pipe_if.slave bus
);

  logic             r_v1;
  logic             r_v2;
  logic             r_v3;
  logic             r_s1_sign;
  logic [INT_W-1:0] r_s1_mag;
  stage_t           r_s2;
  logic [INT_W-1:0] r_y;

  logic             w_s1_load;
  logic             w_s2_load;
  logic             w_s3_load;
  logic [INT_W-1:0] w_mag;
  logic [5:0]       w_lzc;
  logic [INT_W-1:0] w_norm;
  stage_t           w_s2_next;
  logic [INT_W-1:0] w_y_next;

  // A stage loads when empty or when its contents move on this cycle.
  assign w_s3_load    = !r_v3 || bus.out_ready;
  assign w_s2_load    = !r_v2 || w_s3_load;
  assign w_s1_load    = !r_v1 || w_s2_load;
  assign bus.in_ready = w_s1_load;

  // Unsigned negate: -2^31 maps onto 0x80000000, which is its true magnitude.
  assign w_mag = bus.in_x[INT_W-1] ? (~bus.in_x + 32'd1) : bus.in_x;

  lzc32 u_lzc (
    .i_x   (r_s1_mag),
    .o_cnt (w_lzc)
  );

  assign w_norm = r_s1_mag << w_lzc[4:0];

  always_comb begin
    w_s2_next        = '0;
    w_s2_next.sign   = r_s1_sign;
    w_s2_next.exp    = 8'(EXP_BIAS + INT_W - 1) - {2'b00, w_lzc};
    w_s2_next.sig    = w_norm[INT_W-1 -: SIG_W];
    w_s2_next.guard  = w_norm[INT_W-SIG_W-1];
    w_s2_next.sticky = |w_norm[INT_W-SIG_W-2:0];
    w_s2_next.zero   = w_lzc[5];
  end

`ifdef ITOF_RNE_EN
  logic             w_inc;
  logic [SIG_W:0]   w_sum;

  assign w_inc = r_s2.guard & (r_s2.sticky | r_s2.sig[0]);
  assign w_sum = {1'b0, r_s2.sig} + {{SIG_W{1'b0}}, w_inc};

  // A carry out of the significand leaves it at 1.0, so only the exponent moves.
  always_comb begin
    w_y_next = '0;
    if (!r_s2.zero) begin
      if (w_sum[SIG_W])
        w_y_next = {r_s2.sign, r_s2.exp + 8'd1, {FRAC_W{1'b0}}};
      else
        w_y_next = {r_s2.sign, r_s2.exp, w_sum[FRAC_W-1:0]};
    end
  end
`else
  always_comb begin
    w_y_next = '0;
    if (!r_s2.zero)
      w_y_next = {r_s2.sign, r_s2.exp, r_s2.sig[FRAC_W-1:0]};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_y  <= '0;
    end else begin
      if (w_s1_load) begin
        r_v1 <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_sign <= bus.in_x[INT_W-1];
          r_s1_mag  <= w_mag;
        end
      end
      if (w_s2_load) begin
        r_v2 <= r_v1;
        if (r_v1) r_s2 <= w_s2_next;
      end
      if (w_s3_load) begin
        r_v3 <= r_v2;
        if (r_v2) r_y <= w_y_next;
      end
    end
  end

  assign bus.out_valid = r_v3;
  assign bus.out_y     = r_y;

endmodule

// File: tb/tb_itof_pipe.sv
// tb/tb_itof_pipe.sv - directed self-checking bench for itof_pipe (expectations follow ITOF_RNE_EN)
module tb_itof_pipe;

`ifdef ITOF_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic clk;
  logic rst;

  itof_pipe_if bus ();

  itof_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks;
  int errors;

  logic [31:0] q_in[$];
  logic [31:0] q_exp[$];
  logic [31:0] q_out[$];
  int          q_cyc[$];
  int          n_unstable;
  int          n_bad_ready;
  int          n_ready_low;
  bit          timed_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // mode 0: out_ready held high; mode 1: out_ready follows 1,0,0,1 per cycle.
  task automatic run_stream(input int mode, input int budget);
    int          idx;
    int          cyc;
    logic        prev_v;
    logic        prev_rdy;
    logic [31:0] prev_y;
    logic        exp_rdy;
    q_out.delete();
    q_cyc.delete();
    n_unstable  = 0;
    n_bad_ready = 0;
    n_ready_low = 0;
    idx         = 0;
    cyc         = 0;
    prev_v      = 1'b0;
    prev_rdy    = 1'b1;
    prev_y      = '0;
    while (q_out.size() < q_in.size() && cyc < budget) begin
      bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      bus.in_valid  = (idx < q_in.size());
      bus.in_x      = (idx < q_in.size()) ? q_in[idx] : 32'd0;
      #1;
      if (prev_v && !prev_rdy && (bus.out_valid !== 1'b1 || bus.out_y !== prev_y))
        n_unstable++;
      exp_rdy = !(((idx - q_out.size()) == 3) && !bus.out_ready);
      if (bus.in_ready !== exp_rdy) n_bad_ready++;
      if (bus.in_ready === 1'b0) n_ready_low++;
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) begin
        q_out.push_back(bus.out_y);
        q_cyc.push_back(cyc);
      end
      prev_v   = bus.out_valid;
      prev_rdy = bus.out_ready;
      prev_y   = bus.out_y;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    timed_out = (q_out.size() < q_in.size());
  endtask

  task automatic test_reset();
    int n_seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_x      = 32'd5;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.out_y !== 32'h0) begin
      errors++;
      $display("FAIL reset_out_y got %h want 00000000", bus.out_y);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    n_seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) n_seen++;
    end
    checks++;
    if (n_seen !== 0) begin
      errors++;
      $display("FAIL reset_cycle_operand emitted %0d results want 0", n_seen);
    end
  endtask

  task automatic test_basic();
    q_in  = '{32'd1, 32'hFFFF_FFFF, 32'd0};
    q_exp = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
    run_stream(0, 40);
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL basic_timeout got %0d results want %0d", q_out.size(), q_in.size());
    end
    for (int k = 0; k < q_exp.size(); k++) begin
      checks++;
      if (k >= q_out.size()) begin
        errors++;
        $display("FAIL basic_missing[%0d] got none want %h", k, q_exp[k]);
      end else begin
        if (q_out[k] !== q_exp[k]) begin
          errors++;
          $display("FAIL basic_value[%0d] got %h want %h", k, q_out[k], q_exp[k]);
        end
        checks++;
        if (q_cyc[k] !== 3 + k) begin
          errors++;
          $display("FAIL basic_latency[%0d] got cycle %0d want %0d", k, q_cyc[k], 3 + k);
        end
      end
    end
  endtask

  task automatic test_rounding();
    q_in  = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd16777217, 32'd16777219, 32'd16777218,
              32'h00FF_FFFF, 32'h7FFF_FF80, 32'd2, 32'hFFFF_FFFB, 32'd100, 32'hFFFF_FF81};
    q_exp = '{32'hCF00_0000, RNE ? 32'h4F00_0000 : 32'h4EFF_FFFF, 32'h4B80_0000,
              RNE ? 32'h4B80_0002 : 32'h4B80_0001, 32'h4B80_0001,
              32'h4B7F_FFFF, 32'h4EFF_FFFF, 32'h4000_0000, 32'hC0A0_0000,
              32'h42C8_0000, 32'hC2FE_0000};
    run_stream(0, 60);
    checks++;
    if (q_out.size() !== q_exp.size()) begin
      errors++;
      $display("FAIL round_count got %0d want %0d", q_out.size(), q_exp.size());
    end
    for (int k = 0; k < q_exp.size() && k < q_out.size(); k++) begin
      checks++;
      if (q_out[k] !== q_exp[k]) begin
        errors++;
        $display("FAIL round_value x=%h got %h want %h", q_in[k], q_out[k], q_exp[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    q_in  = '{32'd4, 32'd8, 32'hFFFF_FFFE, 32'd0, 32'd1, 32'd3, 32'd7, 32'd16};
    q_exp = '{32'h4080_0000, 32'h4100_0000, 32'hC000_0000, 32'h0000_0000,
              32'h3F80_0000, 32'h4040_0000, 32'h40E0_0000, 32'h4180_0000};
    run_stream(0, 40);
    checks++;
    if (q_out.size() !== q_exp.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d want %0d", q_out.size(), q_exp.size());
    end
    for (int k = 0; k < q_exp.size() && k < q_out.size(); k++) begin
      checks++;
      if (q_out[k] !== q_exp[k] || q_cyc[k] !== 3 + k) begin
        errors++;
        $display("FAIL b2b[%0d] got %h at cycle %0d want %h at cycle %0d",
                 k, q_out[k], q_cyc[k], q_exp[k], 3 + k);
      end
    end
  endtask

  task automatic test_stall();
    q_in  = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd100, 32'd0,
              32'h8000_0000, 32'h7FFF_FFFF, 32'd16777219};
    q_exp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'hBF80_0000,
              32'hC0A0_0000, 32'h42C8_0000, 32'h0000_0000, 32'hCF00_0000,
              RNE ? 32'h4F00_0000 : 32'h4EFF_FFFF,
              RNE ? 32'h4B80_0002 : 32'h4B80_0001};
    run_stream(1, 200);
    checks++;
    if (q_out.size() !== q_exp.size()) begin
      errors++;
      $display("FAIL stall_count got %0d want %0d", q_out.size(), q_exp.size());
    end
    for (int k = 0; k < q_exp.size() && k < q_out.size(); k++) begin
      checks++;
      if (q_out[k] !== q_exp[k]) begin
        errors++;
        $display("FAIL stall_value[%0d] got %h want %h", k, q_out[k], q_exp[k]);
      end
    end
    checks++;
    if (n_unstable !== 0) begin
      errors++;
      $display("FAIL stall_hold got %0d unstable cycles want 0", n_unstable);
    end
    checks++;
    if (n_bad_ready !== 0) begin
      errors++;
      $display("FAIL stall_in_ready got %0d wrong cycles want 0", n_bad_ready);
    end
    checks++;
    if (n_ready_low == 0) begin
      errors++;
      $display("FAIL stall_backpressure got %0d low cycles want >0", n_ready_low);
    end
  endtask

  task automatic test_reset_flush();
    int n_seen;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 32'd10 + i;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_full_in_ready got %b want 0", bus.in_ready);
    end
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_x     = 32'd7;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_y !== 32'h0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state got v=%b y=%h r=%b want v=0 y=00000000 r=1",
               bus.out_valid, bus.out_y, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    n_seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) n_seen++;
    end
    checks++;
    if (n_seen !== 0) begin
      errors++;
      $display("FAIL flush_emitted got %0d results want 0", n_seen);
    end
    q_in = '{32'hFFFF_FFFF};
    run_stream(0, 20);
    checks++;
    if (q_out.size() !== 1 || q_out[0] !== 32'hBF80_0000) begin
      errors++;
      $display("FAIL flush_recover got %0d results first %h want 1 result bf800000",
               q_out.size(), (q_out.size() > 0) ? q_out[0] : 32'h0);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_rounding();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/itof_pipe.md
ITOF_PIPE -- requirements
Module: itof_pipe

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1: in_x holds a valid operand.
REQ-004 SHALL have port in_ready, output, 1: operand accepted on a cycle where in_valid && in_ready.
REQ-005 SHALL have port in_x, input, 32: two's-complement signed integer.
REQ-006 SHALL have port out_valid, output, 1: out_y holds a result.
REQ-007 SHALL have port out_ready, input, 1: result consumed on a cycle where out_valid && out_ready.
REQ-008 SHALL have port out_y, output, 32: IEEE-754 single {sign, exp[7:0], frac[22:0]}.
REQ-009 SHALL have no parameters; widths are fixed at 32.

Function
REQ-010 SHALL convert in_x to the nearest representable single under the rounding rule of REQ-024/025; no denormals, NaN or Inf are ever produced.
REQ-011 SHALL be a 3-stage pipeline: S1 sign + magnitude (33-bit safe for -2^31), S2 leading-zero count + left-normalize, S3 round + exponent + pack.
REQ-012 SHALL hold one valid bit per stage; a stage loads when it is empty or its contents move forward in the same cycle.
REQ-013 SHALL drive in_ready = !v1 || S1 advances; combinational from out_ready through the stage valid bits, no combinational path from in_valid or in_x.
REQ-014 SHALL give latency 3 cycles from acceptance to out_valid with out_ready held high, and throughput 1 result/cycle.
REQ-015 SHALL hold out_y and out_valid stable while out_valid && !out_ready.
REQ-016 SHALL preserve operand order; no result dropped or duplicated under any stall pattern.
REQ-017 SHALL map 0 to 0x00000000 (positive zero), bypassing the LZC path.
REQ-018 SHALL map -2^31 (0x80000000) to 0xCF000000 exactly.
REQ-019 SHALL set exp = 127 + (31 - lzc) for nonzero magnitude before rounding.
REQ-020 SHALL, when rounding carries out of the 24-bit significand, set frac = 0 and increment exp by 1 (e.g. 2^31-1 under RNE -> 0x4F000000).
REQ-021 SHALL, for magnitudes < 2^24, produce an exact result (no rounding).
REQ-022 SHALL accept simultaneous acceptance at S1 and emission at S3 in one cycle without a bubble.

Reset
REQ-023 SHALL, on rst high at a clock edge, clear v1..v3, drive out_valid = 0 and out_y = 0x00000000 and in_ready = 1 on the following cycle, discarding in-flight operands; an operand offered in the reset cycle is not accepted.

Configuration
REQ-024 SHALL, with macro ITOF_RNE_EN defined, round to nearest, ties to even, using guard and sticky bits from S2.
REQ-025 SHALL, without ITOF_RNE_EN, truncate toward zero (drop bits below frac LSB); no carry logic is generated.

Structure
REQ-026 SHALL place the exponent bias (127), width constants and a stage-payload struct typedef (sign, exp, 24-bit significand, guard, sticky, zero flag) in the shared FPU package fpu_pkg.
REQ-027 SHALL instantiate one sub-module lzc32: combinational 32-bit leading-zero counter, output 6 bits, 32 for zero input.

Verification
REQ-028 Reset then in_x = 1, 0xFFFFFFFF (-1), 0 back-to-back, out_ready = 1 -> out_y 0x3F800000, 0xBF800000, 0x00000000 on cycles 3, 4, 5 after first acceptance.
REQ-029 in_x = 0x80000000 -> 0xCF000000; in_x = 0x7FFFFFFF -> 0x4F000000 (RNE) / 0x4EFFFFFF (truncate).
REQ-030 in_x = 16777217 -> 0x4B800000 both modes; in_x = 16777219 -> 0x4B800002 (RNE) / 0x4B800001 (truncate).
REQ-031 Stream 10 operands with out_ready toggling 1,0,0,1 pattern -> all 10 results in order, out_y stable during stalls, in_ready low only when all three stages full and out_ready = 0.
REQ-032 Assert rst with 3 operands in flight -> next cycle out_valid = 0, out_y = 0, in_ready = 1; none of the 3 results ever emitted.
REQ-033 Random 10^5 signed operands vs. software int-to-float (matching compiled rounding mode) -> bit-exact match.
